// File: rtl/text_pkg.sv
// Character constants and byte-mapping helpers shared by the text normalizer
// and the downstream begin/end block checker.
package text_pkg;

    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_TAB   = 8'h09;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_UA    = 8'h41;
    localparam logic [7:0] CH_UZ    = 8'h5A;
    localparam logic [7:0] CASE_OFS = 8'h20;

    function automatic logic is_ws(input logic [7:0] c);
        return (c == CH_SPACE) || (c == CH_TAB) || (c == CH_LF) || (c == CH_CR);
    endfunction

    // Upper-case letters fold to lower case; every whitespace byte becomes a space.
    function automatic logic [7:0] norm_char(input logic [7:0] c);
        logic [7:0] r;
        r = c;
        if ((c >= CH_UA) && (c <= CH_UZ)) begin
            r = c + CASE_OFS;
        end else if (is_ws(c)) begin
            r = CH_SPACE;
        end
        return r;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO: the head entry is visible on
// dout_o whenever the FIFO is not empty, and reads 0 when it is.
module sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           din_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           dout_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == CNT_FULL);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

    // Guards make a push into a full FIFO or a pop from an empty one a no-op.
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    assign dout_o = empty_o ? '0 : mem[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= din_i;
        end
    end

endmodule

// File: rtl/text_normalizer.sv
// Lowercases letters, maps whitespace to a space and collapses whitespace runs
// before buffering the characters for the begin/end block checker.
module text_normalizer
    import text_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [7:0]       out_data,
    input  logic             out_ready,
    output logic [CNT_W-1:0] drop_count
);

    // Handshake: a beat transfers on a rising clk edge where valid && ready.
    // in_ready depends only on FIFO fullness; out_valid only on emptiness.

    localparam int AW = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] DROP_MAX = '1;
    localparam logic [CNT_W-1:0] DROP_ONE = CNT_W'(1);
    localparam logic [AW:0]      CNT_FULL = (AW + 1)'(DEPTH);

    logic             last_space_q, last_space_d;
    logic [CNT_W-1:0] drop_count_q, drop_count_d;
    logic             acc, mapped_is_space, drop, push, pop;
    logic [7:0]       mapped;
    logic             fifo_full, fifo_empty;
    logic [AW:0]      fifo_count;

    assign in_ready        = !fifo_full;
    assign out_valid       = !fifo_empty;
    assign acc             = in_valid && in_ready;
    assign mapped          = norm_char(in_data);
    assign mapped_is_space = (mapped == CH_SPACE);
    assign drop            = acc && mapped_is_space && last_space_q;
    assign push            = acc && !drop;
    assign pop             = out_valid && out_ready;
    assign drop_count      = drop_count_q;

    always_comb begin
        last_space_d = last_space_q;
        drop_count_d = drop_count_q;
        if (push) begin
            last_space_d = mapped_is_space;
        end
        if (drop && (drop_count_q != DROP_MAX)) begin
            drop_count_d = drop_count_q + DROP_ONE;
        end
    end

    // last_space resets to 1 so whitespace at the start of a stream is dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_space_q <= 1'b1;
            drop_count_q <= '0;
        end else begin
            last_space_q <= last_space_d;
            drop_count_q <= drop_count_d;
        end
    end

    sync_fifo #(
        .DEPTH(DEPTH),
        .WIDTH(8)
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .push_i (push),
        .din_i  (mapped),
        .pop_i  (pop),
        .dout_o (out_data),
        .full_o (fifo_full),
        .empty_o(fifo_empty),
        .count_o(fifo_count)
    );

    a_count_bound: assert property (@(posedge clk) disable iff (reset)
        fifo_count <= CNT_FULL);

endmodule

// File: tb/tb_text_normalizer.sv
// Directed bench for text_normalizer: case/whitespace mapping, collapsing,
// backpressure at full, pointer wrap, counter saturation and async reset.
module tb_text_normalizer;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, out_ready, in_ready, out_valid;
    logic [7:0]  in_data, out_data;
    logic [15:0] drop_count;

    logic        b_in_valid, b_out_ready, b_in_ready, b_out_valid;
    logic [7:0]  b_in_data, b_out_data;
    logic [3:0]  b_drop_count;

    logic [7:0]  got_q[$];
    logic [7:0]  got2_q[$];
    logic [7:0]  exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;

    text_normalizer #(.DEPTH(DEPTH), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
        .out_ready(out_ready), .drop_count(drop_count)
    );

    text_normalizer #(.DEPTH(DEPTH), .CNT_W(4)) dut_sat (
        .clk(clk), .reset(reset), .in_valid(b_in_valid), .in_data(b_in_data),
        .in_ready(b_in_ready), .out_valid(b_out_valid), .out_data(b_out_data),
        .out_ready(b_out_ready), .drop_count(b_drop_count)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    // Inputs only change 1 time unit after a rising edge, so a negedge sample
    // of valid && ready is exactly the beat taken at the next rising edge.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) got_q.push_back(out_data);
        if (!reset && b_out_valid && b_out_ready) got2_q.push_back(b_out_data);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        b_in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        got_q.delete();
        got2_q.delete();
    endtask

    // driver tasks
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data = b;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("send_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic send_byte2(input logic [7:0] b);
        int n;
        n = 0;
        b_in_valid = 1'b1;
        b_in_data = b;
        @(negedge clk);
        while (!b_in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!b_in_ready) check("send2_timeout", 32'(b_in_ready), 32'd1);
        @(posedge clk);
        #1 b_in_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    // scoreboard: drain, then compare captured beats against the expected string
    task automatic expect_str(input string tag, input string s);
        logic [7:0] g;
        repeat (DEPTH + 4) @(posedge clk);
        #1;
        exp_q.delete();
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
        check({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
        while (exp_q.size() > 0) begin
            g = (got_q.size() > 0) ? got_q.pop_front() : 8'hFF;
            check({tag, "_chr"}, 32'(g), 32'(exp_q.pop_front()));
        end
        got_q.delete();
    endtask

    initial begin
        string s3;
        int    bad_cnt;
        logic [7:0] g;

        reset = 1'b1;
        in_valid = 1'b0;
        in_data = 8'h00;
        out_ready = 1'b1;
        b_in_valid = 1'b0;
        b_in_data = 8'h00;
        b_out_ready = 1'b1;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_drop", 32'(drop_count), 32'd0);
        do_reset();

        // leading whitespace and upper case
        send_str(" \t BEGIN");
        expect_str("begin", "begin");
        check("begin_drop", 32'(drop_count), 32'd3);

        // CR/LF runs collapse into one space
        do_reset();
        send_str("end\r\n\n  x");
        expect_str("endx", "end x");
        check("endx_drop", 32'(drop_count), 32'd4);

        // backpressure at full
        do_reset();
        out_ready = 1'b0;
        s3 = "abcdefghij";
        for (int i = 0; i < 8; i++) begin
            send_byte(s3[i]);
            if (i == 0) begin
                check("lat_valid", 32'(out_valid), 32'd1);
                check("lat_data", 32'(out_data), 32'h61);
            end
        end
        check("full_ready", 32'(in_ready), 32'd0);
        check("full_count", 32'(dut.u_fifo.count_o), 32'd8);
        in_valid = 1'b1;
        in_data = s3[8];
        repeat (2) @(posedge clk);
        #1 check("full_hold", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        check("pop_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        check("refill_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        send_byte(s3[9]);
        expect_str("full", "abcdefghij");

        // streaming through a full FIFO across pointer wrap
        do_reset();
        out_ready = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 8; i++) send_byte(8'h61 + 8'(i));
        out_ready = 1'b1;
        bad_cnt = 0;
        for (int i = 8; i < 32; i++) begin
            send_byte(8'h61 + 8'(i % 26));
            if (dut.u_fifo.count_o < 7) bad_cnt++;
        end
        check("wrap_count_range", 32'(bad_cnt), 32'd0);
        repeat (DEPTH + 4) @(posedge clk);
        #1 check("wrap_len", 32'(got_q.size()), 32'd32);
        for (int i = 0; i < 32; i++) begin
            g = (got_q.size() > 0) ? got_q.pop_front() : 8'hFF;
            check("wrap_chr", 32'(g), 32'(8'h61 + 8'(i % 26)));
        end
        got_q.delete();

        // drop counter saturation on the narrow-counter instance
        do_reset();
        send_byte2(8'h61);
        for (int i = 0; i < 20; i++) send_byte2(8'h20);
        repeat (DEPTH + 4) @(posedge clk);
        #1;
        check("sat_drop", 32'(b_drop_count), 32'd15);
        check("sat_len", 32'(got2_q.size()), 32'd2);
        g = (got2_q.size() > 0) ? got2_q.pop_front() : 8'hFF;
        check("sat_chr0", 32'(g), 32'h61);
        g = (got2_q.size() > 0) ? got2_q.pop_front() : 8'hFF;
        check("sat_chr1", 32'(g), 32'h20);

        // asynchronous reset with buffered data
        do_reset();
        out_ready = 1'b0;
        send_str("vwxyz");
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("async_out_valid", 32'(out_valid), 32'd0);
        check("async_out_data", 32'(out_data), 32'd0);
        check("async_in_ready", 32'(in_ready), 32'd1);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        got_q.delete();
        out_ready = 1'b1;
        send_str(" ab");
        expect_str("post_rst", "ab");
        check("post_rst_drop", 32'(drop_count), 32'd1);

        // final report
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
